// File: rtl/mul_vec_pipe_if.sv
// mul_vec_pipe_if: input/output handshake bundle for mul_vec_pipe.
//   in_valid/in_ready/in_mode : input beat handshake and per-beat mode (0 elem, 1 dot)
//   inA_vec/inB_vec           : packed operand vectors, lane i at [i*DW +: DW]
//   out_valid/out_ready       : result beat handshake
//   out_vec/out_sat           : packed result vector and saturation flag
interface mul_vec_pipe_if #(
    parameter int LANES = 25,
    parameter int DW    = 16
);
    logic                in_valid, in_ready, in_mode;
    logic                out_valid, out_ready, out_sat;
    logic [LANES*DW-1:0] inA_vec, inB_vec, out_vec;
    modport master (
        output in_valid, in_mode, inA_vec, inB_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_sat
    );
    modport slave (
        input  in_valid, in_mode, inA_vec, inB_vec, out_ready,
        output in_ready, out_valid, out_vec, out_sat
    );
endinterface

// File: rtl/mul_vec_pipe.sv
// mul_vec_pipe: two-stage fixed-point vector multiplier (element-wise or dot product).
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mul_vec_pipe_if slave (operands in, results out, valid/ready both sides)
// S1 holds full-precision lane products; S2 holds rounded, saturated results.
module mul_vec_pipe #(
    parameter int LANES = 25,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input logic         clk,
    input logic         rst_n,
    mul_vec_pipe_if.slave bus
);
    localparam int PW = 2 * DW;
    // One bit of headroom over the dot accumulator so the rounding add cannot wrap.
    localparam int AW = PW + $clog2(LANES) + 1;
    localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Round half up, shift down, clamp; returns {saturated, value}.
    function automatic logic [DW:0] clamp(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = (v + HALF) >>> FRAC;
        return (s > MAXV) ? {1'b1, MAXV[DW-1:0]} :
               (s < MINV) ? {1'b1, MINV[DW-1:0]} : {1'b0, s[DW-1:0]};
    endfunction

    logic                  adv;
    logic signed [PW-1:0]  prod_d [LANES];
    logic signed [PW-1:0]  prod_q [LANES];
    logic signed [AW-1:0]  ext    [LANES];
    logic [DW:0]           lane_r [LANES];
    logic signed [AW-1:0]  acc;
    logic [DW:0]           dot_r;
    logic                  mode_q, v1_q, out_valid_q, out_sat_q, out_sat_d;
    logic [LANES*DW-1:0]   out_vec_q, out_vec_d;

    assign adv           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_sat   = out_sat_q;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic signed [PW-1:0] a, b;
        assign a         = {{DW{bus.inA_vec[g*DW+DW-1]}}, bus.inA_vec[g*DW +: DW]};
        assign b         = {{DW{bus.inB_vec[g*DW+DW-1]}}, bus.inB_vec[g*DW +: DW]};
        assign prod_d[g] = a * b;
        assign ext[g]    = {{(AW-PW){prod_q[g][PW-1]}}, prod_q[g]};
        assign lane_r[g] = clamp(ext[g]);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < LANES; i++) acc = acc + ext[i];
    end

    assign dot_r = clamp(acc);

    always_comb begin
        out_vec_d = '0;
        out_sat_d = 1'b0;
        if (mode_q) begin
            out_vec_d[DW-1:0] = dot_r[DW-1:0];
            out_sat_d         = dot_r[DW];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                out_vec_d[i*DW +: DW] = lane_r[i][DW-1:0];
                out_sat_d             = out_sat_d | lane_r[i][DW];
            end
        end
    end

    // Products and mode need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            prod_q      <= prod_d;
            mode_q      <= bus.in_mode;
            v1_q        <= bus.in_valid;
            out_valid_q <= v1_q;
            out_vec_q   <= out_vec_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_mul_vec_pipe.sv
// tb_mul_vec_pipe: directed self-checking bench for mul_vec_pipe.
module tb_mul_vec_pipe;
    localparam int LANES = 25;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int W     = LANES * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_vec_pipe_if #(.LANES(LANES), .DW(DW)) bus ();
    mul_vec_pipe #(.LANES(LANES), .DW(DW), .FRAC(FRAC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [15:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = x;
        return r;
    endfunction

    function automatic logic [W-1:0] lane0(input logic [15:0] x);
        logic [W-1:0] r;
        r = '0;
        r[15:0] = x;
        return r;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        bus.inA_vec  = a;
        bus.inB_vec  = b;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input logic [W-1:0] ev, input logic es);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        drive(a, b, m);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_valid"}, W'(bus.out_valid), W'(1'b1));
        check(tag, bus.out_vec, ev);
        check({tag, "_sat"}, W'(bus.out_sat), W'(es));
    endtask

    initial begin
        int sent, rcvd, cycles;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.inA_vec   = '0;
        bus.inB_vec   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", W'(bus.out_valid), W'(1'b0));
        check("rst_vec", bus.out_vec, '0);
        check("rst_sat", W'(bus.out_sat), W'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(bus.in_ready), W'(1'b1));

        run_beat("elem", rep(16'h05C0), rep(16'hF540), 1'b0, rep(16'hC230), 1'b0);
        run_beat("dot_sat", rep(16'h05C0), rep(16'hF540), 1'b1, lane0(16'h8000), 1'b1);
        run_beat("round_up", lane0(16'h0001), lane0(16'h0080), 1'b0, lane0(16'h0001), 1'b0);
        run_beat("round_neg", lane0(16'hFFFF), lane0(16'h0080), 1'b0, lane0(16'h0000), 1'b0);
        run_beat("clamp_pos", lane0(16'h7FFF), lane0(16'h7FFF), 1'b0, lane0(16'h7FFF), 1'b1);
        run_beat("clamp_min2", lane0(16'h8000), lane0(16'h8000), 1'b0, lane0(16'h7FFF), 1'b1);
        run_beat("clamp_neg", lane0(16'h8000), lane0(16'h7FFF), 1'b0, lane0(16'h8000), 1'b1);

        // Back-to-back beats of different modes.
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        drive(rep(16'h0100), rep(16'h0200), 1'b0);
        @(posedge clk); #1;
        drive(rep(16'h0100), rep(16'h0200), 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mix_elem", bus.out_vec, rep(16'h0200));
        check("mix_elem_valid", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;
        check("mix_dot", bus.out_vec, lane0(16'h3200));
        check("mix_dot_valid", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;
        check("mix_drain", W'(bus.out_valid), W'(1'b0));

        // Backpressure stream with random out_ready.
        sent = 0;
        rcvd = 0;
        cycles = 0;
        while (rcvd < 10 && cycles < 500) begin
            @(posedge clk); #1;
            bus.in_valid  = (sent < 10);
            bus.in_mode   = 1'b0;
            bus.inA_vec   = lane0(16'((sent + 1) * 256));
            bus.inB_vec   = lane0(16'h0100);
            bus.out_ready = 1'($urandom % 2);
            @(negedge clk);
            check("bp_ready", W'(bus.in_ready), W'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                check("bp_data", bus.out_vec, lane0(16'((rcvd + 1) * 256)));
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cycles++;
        end
        check("bp_count", W'(rcvd), W'(10));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_no_extra", W'(bus.out_valid), W'(1'b0));
        end

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive(rep(16'h0300), rep(16'h0100), 1'b0);
        @(posedge clk); #1;
        drive(rep(16'h0400), rep(16'h0100), 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mid_held", W'(bus.out_valid), W'(1'b1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        check("mid_rst_valid", W'(bus.out_valid), W'(1'b0));
        repeat (3) begin
            @(negedge clk);
            check("mid_dropped", W'(bus.out_valid), W'(1'b0));
        end
        run_beat("after_rst", rep(16'h0100), rep(16'h0180), 1'b0, rep(16'h0180), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
